// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1:2 demultiplexer.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    localparam logic SEL_A  = 1'b1;
    localparam logic SEL_B  = 1'b0;

    localparam int   NUM_CH = 2;
    localparam int   CH_A   = 0;
    localparam int   CH_B   = 1;

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready holding register. A word is held stable while FULL.
// The register can drain and refill in the same cycle.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         free
);

    chan_state_t state;

    // q keeps the last loaded word while EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            q     <= '0;
        end else if (load) begin
            state <= FULL;
            q     <= d;
        end else if (ready) begin
            state <= EMPTY;
        end
    end

    assign valid = (state == FULL);
    assign free  = (state == EMPTY) || ready;

endmodule

// File: rtl/demux1_2r.sv
// Registered 1:2 demultiplexer with per-channel back-pressure and atomic broadcast.
// Optional per-channel drain counters are enabled with DEMUX_CNT_EN.
module demux1_2r
    import demux_pkg::*;
#(
    parameter int W = 4
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic             bcast,
    input  logic [W-1:0]     din,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [W-1:0]     doutA,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [W-1:0]     doutB
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB
`endif
);

    logic [NUM_CH-1:0]        load;
    logic [NUM_CH-1:0]        rdy;
    logic [NUM_CH-1:0]        vld;
    logic [NUM_CH-1:0]        fre;
    logic [NUM_CH-1:0][W-1:0] q;
    logic                     accept;

    assign rdy[CH_A] = a_ready;
    assign rdy[CH_B] = b_ready;

    // A broadcast needs both channels free so that neither loads alone.
    assign in_ready = bcast ? (fre[CH_A] & fre[CH_B])
                            : ((sel == SEL_A) ? fre[CH_A] : fre[CH_B]);
    assign accept   = in_valid & in_ready;

    assign load[CH_A] = accept & (bcast | (sel == SEL_A));
    assign load[CH_B] = accept & (bcast | (sel == SEL_B));

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        demux_out_reg #(.W(W)) u_reg (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[ch]),
            .d     (din),
            .ready (rdy[ch]),
            .valid (vld[ch]),
            .q     (q[ch]),
            .free  (fre[ch])
        );
    end

    assign a_valid = vld[CH_A];
    assign b_valid = vld[CH_B];
    assign doutA   = q[CH_A];
    assign doutB   = q[CH_B];

`ifdef DEMUX_CNT_EN
    // Counters advance on drain, so a broadcast word counts once per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntA <= '0;
            cntB <= '0;
        end else begin
            if (vld[CH_A] & rdy[CH_A]) cntA <= cntA + 1'b1;
            if (vld[CH_B] & rdy[CH_B]) cntB <= cntB + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux1_2r.sv
// Directed bench for demux1_2r: queue-based channel model checked every cycle
// plus hand-computed literal expectations.
module tb_demux1_2r;

    localparam int W = 4;
`ifdef DEMUX_CNT_EN
    localparam int CNT_W = 2;
    logic [CNT_W-1:0] cntA, cntB;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         sel = 1'b0;
    logic         bcast = 1'b0;
    logic         a_ready = 1'b0;
    logic         b_ready = 1'b0;
    logic [W-1:0] din = '0;
    logic         in_ready, a_valid, b_valid;
    logic [W-1:0] doutA, doutB;

    always #5 clk = ~clk;

    demux1_2r #(
        .W(W)
`ifdef DEMUX_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .bcast    (bcast),
        .din      (din),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .doutA    (doutA),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .doutB    (doutB)
`ifdef DEMUX_CNT_EN
        , .cntA   (cntA),
        .cntB     (cntB)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue of at most one word; counters are drain tallies.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           ca = 0;
    int           cb = 0;

    function automatic bit exp_in_ready();
        bit fa, fb;
        fa = (qa.size() == 0) || a_ready;
        fb = (qb.size() == 0) || b_ready;
        if (bcast) return fa && fb;
        return sel ? fa : fb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            bit acc;
            acc = in_valid && exp_in_ready();
            if (qa.size() != 0 && a_ready) begin
                void'(qa.pop_front());
                ca = ca + 1;
            end
            if (qb.size() != 0 && b_ready) begin
                void'(qb.pop_front());
                cb = cb + 1;
            end
            if (acc && (bcast || sel))  qa.push_back(din);
            if (acc && (bcast || !sel)) qb.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_a_valid", a_valid, 0);
            chk("rst_b_valid", b_valid, 0);
            chk("rst_doutA", doutA, 0);
            chk("rst_doutB", doutB, 0);
        end else begin
            chk("m_a_valid", a_valid, qa.size() != 0);
            chk("m_b_valid", b_valid, qb.size() != 0);
            if (qa.size() != 0) chk("m_doutA", doutA, qa[0]);
            if (qb.size() != 0) chk("m_doutB", doutB, qb[0]);
            chk("m_in_ready", in_ready, exp_in_ready());
`ifdef DEMUX_CNT_EN
            chk("m_cntA", cntA, ca % (1 << CNT_W));
            chk("m_cntB", cntB, cb % (1 << CNT_W));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic bc, input logic [W-1:0] d);
        in_valid = v;
        sel      = s;
        bcast    = bc;
        din      = d;
    endtask

    initial begin
        // Reset values and in_ready for every sel/bcast combination
        #1;
        chk("rst_a_valid0", a_valid, 0);
        chk("rst_doutA0", doutA, 0);
        chk("rst_doutB0", doutB, 0);
        drive(0, 1, 0, 0); #1 chk("rst_rdy_selA", in_ready, 1);
        drive(0, 0, 0, 0); #1 chk("rst_rdy_selB", in_ready, 1);
        drive(0, 0, 1, 0); #1 chk("rst_rdy_bcast", in_ready, 1);
        drive(0, 0, 0, 0);
`ifdef DEMUX_CNT_EN
        chk("rst_cntA0", cntA, 0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Single word to A, one-cycle latency
        a_ready = 1'b1;
        drive(1, 1, 0, 4'h5);
        step();
        drive(0, 1, 0, 4'h0);
        chk("t1_a_valid", a_valid, 1);
        chk("t1_doutA", doutA, 4'h5);
        chk("t1_b_valid", b_valid, 0);
        step();
        chk("t1_a_drained", a_valid, 0);
`ifdef DEMUX_CNT_EN
        chk("t1_cntA", cntA, 1);
`endif

        // B stalls; A traffic continues
        b_ready = 1'b0;
        drive(1, 0, 0, 4'hA);
        step();
        drive(0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_b_hold_valid", b_valid, 1);
            chk("t2_b_hold_data", doutB, 4'hA);
            step();
        end
        drive(1, 0, 0, 4'h7);
        #1 chk("t2_b_blocked", in_ready, 0);
        drive(1, 1, 0, 4'h3);
        #1 chk("t2_a_open", in_ready, 1);
        step();
        drive(0, 0, 0, 4'h0);
        chk("t2_doutA", doutA, 4'h3);
        chk("t2_doutB_still", doutB, 4'hA);

        // Alternating stream, both consumers ready: no bubbles
        b_ready = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] v;
            v = W'(i);
            drive(1, v[0], 0, v);
            #1 chk("t3_no_bubble", in_ready, 1);
            step();
            if (v[0]) chk("t3_doutA", doutA, v);
            else      chk("t3_doutB", doutB, v);
            chk("t3_valid", v[0] ? a_valid : b_valid, 1);
        end
        drive(0, 0, 0, 4'h0);

        // Broadcast blocked by a full B, then delivered atomically
        b_ready = 1'b0;
        drive(1, 0, 0, 4'h9);
        step();
        drive(1, 0, 1, 4'hF);
        #1 chk("t4_bcast_blocked", in_ready, 0);
        step();
        chk("t4_a_not_loaded", a_valid, 0);
        b_ready = 1'b1;
        #1 chk("t4_bcast_open", in_ready, 1);
        step();
        drive(0, 0, 0, 4'h0);
        chk("t4_doutA", doutA, 4'hF);
        chk("t4_doutB", doutB, 4'hF);
        chk("t4_both_valid", {a_valid, b_valid}, 2'b11);
        step();
        step();

        // Counter wrap: five A drains from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1, 1, 0, W'(i + 1));
            else       drive(0, 1, 0, 4'h0);
            step();
`ifdef DEMUX_CNT_EN
            if (i > 0) chk("t5_cntA_seq", cntA, i % 4);
`endif
        end
        step();

        // Asynchronous reset while both channels are stalled full
        a_ready = 1'b0;
        b_ready = 1'b0;
        drive(1, 1, 0, 4'h6);
        step();
        drive(1, 0, 0, 4'hC);
        step();
        drive(0, 0, 0, 4'h0);
        chk("t6_full", {a_valid, b_valid}, 2'b11);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_a_valid", a_valid, 0);
        chk("t6_async_b_valid", b_valid, 0);
        chk("t6_async_doutA", doutA, 0);
        chk("t6_async_doutB", doutB, 0);
`ifdef DEMUX_CNT_EN
        chk("t6_async_cntA", cntA, 0);
        chk("t6_async_cntB", cntB, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
